// File: rtl/video_timing_gen_pkg.sv
// Shared timing defaults, pattern codes and colour constants for the video timing generator.
package video_timing_gen_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned COLOR_W = 24;
  localparam int unsigned H_MAX   = 2048;
  localparam int unsigned V_MAX   = 1024;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } bgr_t;

  localparam bgr_t BGR_WHITE   = 24'hFFFFFF;
  localparam bgr_t BGR_YELLOW  = 24'h00FFFF;
  localparam bgr_t BGR_CYAN    = 24'hFFFF00;
  localparam bgr_t BGR_GREEN   = 24'h00FF00;
  localparam bgr_t BGR_MAGENTA = 24'hFF00FF;
  localparam bgr_t BGR_RED     = 24'h0000FF;
  localparam bgr_t BGR_BLUE    = 24'hFF0000;
  localparam bgr_t BGR_BLACK   = 24'h000000;

  // Colour of bar idx, left to right; the last bar (and anything past it) is black.
  function automatic bgr_t bar_color(input logic [2:0] idx);
    bgr_t c;
    case (idx)
      3'd0:    c = BGR_WHITE;
      3'd1:    c = BGR_YELLOW;
      3'd2:    c = BGR_CYAN;
      3'd3:    c = BGR_GREEN;
      3'd4:    c = BGR_MAGENTA;
      3'd5:    c = BGR_RED;
      3'd6:    c = BGR_BLUE;
      default: c = BGR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_tpg.sv
// Test-pattern source: one register stage from pipelined coordinates to blanked BGR pixel.
module video_timing_gen_tpg
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de,
  input  logic [H_CNT_W-1:0]   x,
  input  logic [7:0]           y,
  input  logic [FRAME_W-1:0]   frame,
  input  pattern_e             pattern,
  input  logic [COLOR_W-1:0]   color,
  output logic [COLOR_W-1:0]   bgr
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  bgr_t       pix;

  // Bar index by threshold compare; avoids a divider on the pixel path.
  always_comb begin
    bar_idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (x >= H_CNT_W'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  always_comb begin
    pix = BGR_BLACK;
    case (pattern)
      PAT_BARS:  pix = bar_color(bar_idx);
      PAT_GRAD:  pix = '{b: frame, g: y, r: x[7:0]};
      PAT_CHECK: pix = (x[5] ^ y[5]) ? BGR_WHITE : BGR_BLACK;
      PAT_SOLID: pix = bgr_t'(color);
      default:   pix = BGR_BLACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bgr <= '0;
    else     bgr <= de ? COLOR_W'(pix) : '0;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock video timing generator: counters, region decode and sync, feeding the test-pattern stage.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                 i_pxlclk,
  input  logic                 i_rst,
  input  logic [1:0]           i_pattern,
  input  logic [COLOR_W-1:0]   i_color,
  output logic                 o_hs,
  output logic                 o_vs,
  output logic                 o_de,
  output logic [COLOR_W-1:0]   o_bgr,
  output logic [H_CNT_W-1:0]   o_x,
  output logic [V_CNT_W-1:0]   o_y,
  output logic                 o_sof
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > H_MAX || V_TOTAL > V_MAX) begin : g_size_check
    $error("video_timing_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
  end

  logic [H_CNT_W-1:0] h;
  logic [V_CNT_W-1:0] v;
  logic [FRAME_W-1:0] frame;
  pattern_e           pat_q;
  logic [COLOR_W-1:0] color_q;

  logic h_active, v_active, h_sync, v_sync, at_origin;

  logic               s1_hs, s1_vs, s1_de, s1_sof;
  logic [H_CNT_W-1:0] s1_x;
  logic [V_CNT_W-1:0] s1_y;
  logic [FRAME_W-1:0] s1_frame;
  pattern_e           s1_pat;
  logic [COLOR_W-1:0] s1_color;

  // Raster counters and frame counter.
  always_ff @(posedge i_pxlclk or posedge i_rst) begin
    if (i_rst) begin
      h     <= '0;
      v     <= '0;
      frame <= '0;
    end else if (h == H_CNT_W'(H_TOTAL - 1)) begin
      h <= '0;
      if (v == V_CNT_W'(V_TOTAL - 1)) begin
        v     <= '0;
        frame <= frame + FRAME_W'(1);
      end else begin
        v <= v + V_CNT_W'(1);
      end
    end else begin
      h <= h + H_CNT_W'(1);
    end
  end

  always_comb begin
    h_active  = (h < H_CNT_W'(H_ACTIVE));
    v_active  = (v < V_CNT_W'(V_ACTIVE));
    h_sync    = (h >= H_CNT_W'(HS_START)) && (h < H_CNT_W'(HS_END));
    v_sync    = (v >= V_CNT_W'(VS_START)) && (v < V_CNT_W'(VS_END));
    at_origin = (h == '0) && (v == '0);
  end

  // Pattern selection is sampled only at the frame origin so a frame never tears.
  always_ff @(posedge i_pxlclk or posedge i_rst) begin
    if (i_rst) begin
      pat_q   <= PAT_BARS;
      color_q <= '0;
    end else if (at_origin) begin
      pat_q   <= pattern_e'(i_pattern);
      color_q <= i_color;
    end
  end

  // Decode stage.
  always_ff @(posedge i_pxlclk or posedge i_rst) begin
    if (i_rst) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_de    <= 1'b0;
      s1_sof   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_frame <= '0;
      s1_pat   <= PAT_BARS;
      s1_color <= '0;
    end else begin
      s1_hs    <= h_sync;
      s1_vs    <= v_sync;
      s1_de    <= h_active && v_active;
      s1_sof   <= at_origin;
      s1_x     <= h;
      s1_y     <= v;
      s1_frame <= frame;
      s1_pat   <= at_origin ? pattern_e'(i_pattern) : pat_q;
      s1_color <= at_origin ? i_color : color_q;
    end
  end

  // Output stage, aligned with the pixel register inside the pattern source.
  always_ff @(posedge i_pxlclk or posedge i_rst) begin
    if (i_rst) begin
      o_hs  <= ~HS_POL;
      o_vs  <= ~VS_POL;
      o_de  <= 1'b0;
      o_sof <= 1'b0;
      o_x   <= '0;
      o_y   <= '0;
    end else begin
      o_hs  <= s1_hs ? HS_POL : ~HS_POL;
      o_vs  <= s1_vs ? VS_POL : ~VS_POL;
      o_de  <= s1_de;
      o_sof <= s1_sof;
      o_x   <= s1_x;
      o_y   <= s1_y;
    end
  end

  video_timing_gen_tpg #(
    .H_ACTIVE (H_ACTIVE)
  ) u_tpg (
    .clk     (i_pxlclk),
    .rst     (i_rst),
    .de      (s1_de),
    .x       (s1_x),
    .y       (s1_y[7:0]),
    .frame   (s1_frame),
    .pattern (s1_pat),
    .color   (s1_color),
    .bgr     (o_bgr)
  );

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized scoreboard bench: expected pixels are derived from elapsed cycles since reset.
module tb_video_timing_gen;

  localparam int unsigned HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int unsigned VA = 40, VF = 2, VSY = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HSY + HB;
  localparam int unsigned VT = VA + VF + VSY + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned BARW = HA / 8;

  typedef struct {
    logic        hs, vs, de, sof;
    logic [10:0] x;
    logic [9:0]  y;
    logic [23:0] bgr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pattern = 2'd0;
  logic [23:0] color = 24'h0;
  logic        hs, vs, de, sof;
  logic [23:0] bgr;
  logic [10:0] x;
  logic [9:0]  y;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                           24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .i_pxlclk (clk),
    .i_rst    (rst),
    .i_pattern(pattern),
    .i_color  (color),
    .o_hs     (hs),
    .o_vs     (vs),
    .o_de     (de),
    .o_bgr    (bgr),
    .o_x      (x),
    .o_y      (y),
    .o_sof    (sof)
  );

  always #5 clk = ~clk;

  // Reference model: raster position is elapsed cycles modulo line/frame length.
  initial begin
    int unsigned t;
    logic [1:0]  lpat;
    logic [23:0] lcol;
    t = 0;
    lpat = 2'd0;
    lcol = 24'h0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0;
      end else begin
        int unsigned p, h, v, f;
        exp_t e;
        p = t % FRAME;
        h = p % HT;
        v = p / HT;
        f = (t / FRAME) % 256;
        if (p == 0) begin
          lpat = pattern;
          lcol = color;
        end
        e.de  = (h < HA) && (v < VA);
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HSY));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
        e.sof = (p == 0);
        e.x   = 11'(h);
        e.y   = 10'(v);
        if (!e.de)           e.bgr = 24'h0;
        else if (lpat == 0)  e.bgr = (h / BARW >= 7) ? 24'h0 : bars[h / BARW];
        else if (lpat == 1)  e.bgr = {8'(f), 8'(v), 8'(h)};
        else if (lpat == 2)  e.bgr = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
        else                 e.bgr = lcol;
        expq.push_back(e);
        t = t + 1;
      end
    end
  end

  // Monitor: reset values while reset, otherwise compare against the scoreboard.
  initial begin
    int unsigned cyc, last_sof;
    bit          have_sof;
    exp_t        e;
    cyc = 0;
    last_sof = 0;
    have_sof = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (rst) begin
        have_sof = 0;
        checks++;
        if (hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0 || sof !== 1'b0 ||
            bgr !== 24'h0 || x !== 11'h0 || y !== 10'h0) begin
          failures++;
          $display("FAIL reset_state: got hs=%b vs=%b de=%b sof=%b bgr=%h x=%0d y=%0d, need 1 1 0 0 000000 0 0",
                   hs, vs, de, sof, bgr, x, y);
        end
      end else if (expq.size() >= 2) begin
        e = expq.pop_front();
        checks++;
        if (hs !== e.hs || vs !== e.vs || de !== e.de || sof !== e.sof || bgr !== e.bgr ||
            (e.de && (x !== e.x || y !== e.y))) begin
          failures++;
          $display("FAIL pixel(%0d,%0d): got hs=%b vs=%b de=%b sof=%b bgr=%h x=%0d y=%0d, need hs=%b vs=%b de=%b sof=%b bgr=%h",
                   e.x, e.y, hs, vs, de, sof, bgr, x, y, e.hs, e.vs, e.de, e.sof, e.bgr);
        end
        if (sof === 1'b1) begin
          if (have_sof) begin
            checks++;
            if (cyc - last_sof != FRAME) begin
              failures++;
              $display("FAIL sof_period: got %0d, need %0d", cyc - last_sof, FRAME);
            end
          end
          have_sof = 1;
          last_sof = cyc;
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [1:0] seq [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
    tick(5);
    rst = 1'b0;
    // Mid-frame pattern switches must only take effect on the following frame.
    for (int fr = 0; fr < 6; fr++) begin
      int unsigned at;
      at = $urandom_range(1, FRAME - 2);
      tick(at);
      pattern = seq[fr];
      color = $urandom;
      tick(FRAME - at);
    end
    tick(20 * HT + 30);
    rst = 1'b1;
    expq.delete();
    tick(3);
    rst = 1'b0;
    for (int unsigned c = 0; c < 3 * FRAME; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        pattern = 2'($urandom_range(0, 3));
        color = $urandom;
      end
      tick(1);
    end
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
